// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider:
//   - div_state_e   : controller state encoding (IDLE / RUN / DONE)
//   - cnt_width()   : iteration counter width for a given operand width
//   - cla4_carries(): flattened 4-bit carry-lookahead carry equations
// No ports (package).
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    localparam int unsigned DEF_WIDTH = 8;

    // Counter must hold the value WIDTH itself, hence one bit above clog2.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

    // Carries c[0..4] of one 4-bit group, each written as a full
    // sum-of-products of generate/propagate terms and the group carry-in,
    // so no carry depends on a lower carry inside the group.
    function automatic logic [4:0] cla4_carries(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin
    );
        logic [4:0] c;
        logic       acc;
        logic       prod;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            acc = cin;
            for (int j = 0; j <= i; j++) begin
                acc = acc & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & p[k];
                end
                acc = acc | prod;
            end
            c[i+1] = acc;
        end
        return c;
    endfunction

endpackage : div_pkg

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Start/busy/done handshake and operand/result bus of the sequential divider.
//   start       : request, honoured only while the unit is not busy
//   dividend    : unsigned numerator   (WIDTH)
//   divisor     : unsigned denominator (WIDTH)
//   busy        : unit is iterating
//   done        : one-cycle completion pulse, results valid
//   quotient    : result quotient  (WIDTH), held until the next completion
//   remainder   : result remainder (WIDTH), held likewise
//   div_by_zero : last completed request had a zero divisor
// master = requester, slave = divider.
// -----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface : seq_divider_if

// File: rtl/cla_sub_stage.sv
// -----------------------------------------------------------------------------
// cla_sub_stage
// Combinational N-bit subtractor diff = a - b, computed as a + ~b + 1 with
// 4-bit carry-lookahead groups chained group carry-out to carry-in. A top
// group narrower than 4 bits handles N not divisible by 4.
//   a         in  N  minuend
//   b         in  N  subtrahend
//   diff      out N  a - b (modulo 2^N)
//   no_borrow out 1  carry-out of the top group; 1 when a >= b
// -----------------------------------------------------------------------------
module cla_sub_stage
    import div_pkg::*;
#(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    localparam int unsigned NG_FULL = N / 4;
    localparam int unsigned REM     = N % 4;
    localparam int unsigned NG      = NG_FULL + ((REM != 0) ? 1 : 0);

    logic [N-1:0] b_inv;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [NG:0]  gc;

    assign b_inv = ~b;
    assign g     = a & b_inv;
    assign p     = a ^ b_inv;
    // Carry-in of 1 completes the two's complement of b.
    assign gc[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NG_FULL; gi++) begin : g_full
            logic [4:0] c;
            assign c                = cla4_carries(g[4*gi +: 4], p[4*gi +: 4], gc[gi]);
            assign diff[4*gi +: 4]  = p[4*gi +: 4] ^ c[3:0];
            assign gc[gi+1]         = c[4];
        end

        if (REM != 0) begin : g_top
            logic [3:0] g_pad;
            logic [3:0] p_pad;
            logic [4:0] c;
            // Unused upper positions are padded with zero so they never
            // generate or propagate a carry.
            assign g_pad            = {{(4-REM){1'b0}}, g[N-1 -: REM]};
            assign p_pad            = {{(4-REM){1'b0}}, p[N-1 -: REM]};
            assign c                = cla4_carries(g_pad, p_pad, gc[NG_FULL]);
            assign diff[N-1 -: REM] = p[N-1 -: REM] ^ c[REM-1:0];
            assign gc[NG]           = c[REM];
        end
    endgenerate

    assign no_borrow = gc[NG];

endmodule : cla_sub_stage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   WIDTH : operand width, a multiple of 4 and at least 4
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : seq_divider_if slave (start/operands in, busy/done/results out)
// A request with a non-zero divisor completes WIDTH+1 cycles after the start
// cycle; a zero divisor completes on the next cycle with quotient all ones,
// remainder = dividend and div_by_zero set.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH:0]   r_q,     r_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [WIDTH-1:0] d_q,     d_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dbz_q,   dbz_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             no_borrow;

    // Shift the next dividend bit into the partial remainder.
    assign trial = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    cla_sub_stage #(
        .N (WIDTH + 1)
    ) u_sub (
        .a         (trial),
        .b         ({1'b0, d_q}),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    // Next-state, datapath update and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    r_d   = {(WIDTH+1){1'b0}};
                    q_d   = bus.dividend;
                    d_d   = bus.divisor;
                    cnt_d = CNT_W'(WIDTH);
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                        quot_d  = {WIDTH{1'b1}};
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Restoring step: keep the difference only when it did not borrow.
                if (no_borrow) begin
                    r_d = diff;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = trial;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                // Last iteration: publish the values being written this edge.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            r_q     <= {(WIDTH+1){1'b0}};
            q_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule : seq_divider
